// File: rtl/fxp_pkg.sv
// ----------------------------------------------------------------------------
// fxp_pkg
// Shared definitions for the fixed-point divider family.
//   fxdiv_state_t : control states of the iterative divider
//   fxdiv_wn()    : number of quotient bits produced by the division loop
// No ports (package).
// ----------------------------------------------------------------------------
package fxp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fxdiv_state_t;

    // Quotient width: dividend bits, plus divisor and output fraction bits,
    // plus one guard bit used for rounding.
    function automatic int fxdiv_wn(input int wiia, input int wifa,
                                    input int wifb, input int wof);
        return wiia + wifa + wifb + wof + 1;
    endfunction

endpackage

// File: rtl/fxdiv_post.sv
// ----------------------------------------------------------------------------
// fxdiv_post
// Combinational post-processing for the fixed-point dividers: rounding of the
// guard-bit quotient, sign restore, overflow flags and saturation/wrap, plus
// the divide-by-zero result.
// Ports:
//   qg           in  QW  quotient magnitude with one guard bit below the LSB
//   sign         in  1   result sign (dividend sign ^ divisor sign)
//   div0         in  1   divisor was zero
//   dividend_neg in  1   dividend was negative (selects div0 result)
//   out          out WO  final two's complement quotient
//   upflow       out 1   true quotient above max positive
//   downflow     out 1   true quotient below min negative
// ----------------------------------------------------------------------------
module fxdiv_post #(
    parameter int QW    = 25,
    parameter int WO    = 16,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [QW-1:0] qg,
    input  logic          sign,
    input  logic          div0,
    input  logic          dividend_neg,
    output logic [WO-1:0] out,
    output logic          upflow,
    output logic          downflow
);

    // Working width wide enough for both the quotient and the output limits.
    localparam int XW = ((QW > WO) ? QW : WO) + 1;

    localparam logic [WO-1:0] MAX_POS = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] MIN_NEG = {1'b1, {(WO-1){1'b0}}};
    localparam logic [XW-1:0] LIM_POS = {{(XW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic [XW-1:0] LIM_NEG = LIM_POS + {{(XW-1){1'b0}}, 1'b1};

    // Drop the guard bit; adding it first gives round-half-away-from-zero
    // because the value is still a magnitude here.
    function automatic logic [QW-1:0] round_q(input logic [QW-1:0] q);
        logic [QW:0] t;
        if (ROUND != 0)
            t = {1'b0, q} + {{QW{1'b0}}, 1'b1};
        else
            t = {1'b0, q};
        return t[QW:1];
    endfunction

    function automatic logic [WO-1:0] saturate(input logic [XW-1:0] qx,
                                               input logic neg,
                                               input logic over);
        logic [XW-1:0] qs;
        qs = neg ? (~qx + {{(XW-1){1'b0}}, 1'b1}) : qx;
        if (over && (ROOF != 0))
            return neg ? MIN_NEG : MAX_POS;
        return qs[WO-1:0];
    endfunction

    logic [QW-1:0] qm;
    logic [XW-1:0] qx;
    logic          neg;
    logic          over;

    always_comb begin
        qm   = round_q(qg);
        qx   = XW'(qm);
        // A zero magnitude is always reported as +0.
        neg  = sign && (qm != '0);
        over = neg ? (qx > LIM_NEG) : (qx > LIM_POS);

        out      = '0;
        upflow   = 1'b0;
        downflow = 1'b0;
        if (div0) begin
            out      = dividend_neg ? MIN_NEG : MAX_POS;
            upflow   = !dividend_neg;
            downflow = dividend_neg;
        end else begin
            out      = saturate(qx, neg, over);
            upflow   = over && !neg;
            downflow = over && neg;
        end
    end

endmodule

// File: rtl/seq_fixed_point_div.sv
// ----------------------------------------------------------------------------
// seq_fixed_point_div
// Iterative signed fixed-point divider, out = ina / inb. Radix-2 restoring
// division on operand magnitudes, one quotient bit per clock, followed by the
// shared fxdiv_post rounding/saturation stage.
// Ports:
//   rst       in  1          asynchronous reset, active-high
//   clk       in  1          clock
//   in_valid  in  1          operands valid
//   in_ready  out 1          operands accepted this cycle (combinational)
//   ina       in  WIIA+WIFA  dividend, two's complement
//   inb       in  WIIB+WIFB  divisor, two's complement
//   out_valid out 1          result valid
//   out_ready in  1          consumer accepts result
//   out       out WOI+WOF    quotient, two's complement
//   upflow    out 1          true quotient above max positive
//   downflow  out 1          true quotient below min negative
//   div0      out 1          divisor was zero
// Build option: define FXDIV_EARLY_EXIT_EN to skip the division loop when
// either operand is zero (result one cycle after accept).
// ----------------------------------------------------------------------------
module seq_fixed_point_div
    import fxp_pkg::*;
#(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIIA+WIFA-1:0] ina,
    input  logic [WIIB+WIFB-1:0] inb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow,
    output logic                 div0
);

    localparam int WA = WIIA + WIFA;
    localparam int WB = WIIB + WIFB;
    localparam int WO = WOI + WOF;
    localparam int WN = fxdiv_wn(WIIA, WIFA, WIFB, WOF);
    localparam int SH = WIFB + WOF + 1;
    // The loop quotient carries WIFA surplus fraction bits; dropping them by
    // truncation is exact because floor(floor(x)/2^k) == floor(x/2^k).
    localparam int QW = WN - WIFA;
    localparam int CW = $clog2(WN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WN);

    fxdiv_state_t state;
    logic [CW-1:0] cnt_p0;

    logic accept;
    logic last;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign last      = (cnt_p0 == CNT_LAST);

    // Operand magnitudes, one bit wider so the most-negative value is exact.
    logic signed [WA:0] ina_x;
    logic signed [WB:0] inb_x;
    logic [WA:0]        ma;
    logic [WB:0]        mb;
    logic [WN-1:0]      num_load;
    logic [CW-1:0]      cnt_load;

    assign ina_x = {ina[WA-1], ina};
    assign inb_x = {inb[WB-1], inb};
    assign ma    = ina[WA-1] ? -ina_x : ina_x;
    assign mb    = inb[WB-1] ? -inb_x : inb_x;
    // ma never exceeds 2^(WA-1), so its top bit is zero and N fits WN bits.
    assign num_load = {ma[WA-1:0], {SH{1'b0}}};

`ifdef FXDIV_EARLY_EXIT_EN
    assign cnt_load = ((ina == '0) || (inb == '0)) ? CNT_LAST : '0;
`else
    assign cnt_load = '0;
`endif

    // ---- stage p0: operand latch and restoring division loop ----
    logic [WN-1:0] num_p0;
    logic [WB:0]   rem_p0;
    logic [WB:0]   mb_p0;
    logic          sign_p0;
    logic          div0_p0;
    logic          aneg_p0;

    logic [WB+1:0] trial;
    logic          qbit;
    logic [WB+1:0] diff;

    assign trial = {rem_p0, num_p0[WN-1]};
    assign qbit  = (trial >= {1'b0, mb_p0});
    assign diff  = trial - {1'b0, mb_p0};

    always_ff @(posedge clk) begin
        if (accept) begin
            num_p0  <= num_load;
            rem_p0  <= '0;
            mb_p0   <= mb;
            sign_p0 <= ina[WA-1] ^ inb[WB-1];
            div0_p0 <= (inb == '0);
            aneg_p0 <= ina[WA-1];
        end else if ((state == BUSY) && !last && !div0_p0) begin
            // trial < 2*mb <= 2^WB, so the remainder always fits WB+1 bits.
            rem_p0 <= qbit ? diff[WB:0] : trial[WB:0];
            num_p0 <= {num_p0[WN-2:0], qbit};
        end
    end

    // ---- stage p1: post-processing and result register ----
    logic [WO-1:0] post_out;
    logic          post_up;
    logic          post_down;

    fxdiv_post #(
        .QW   (QW),
        .WO   (WO),
        .ROOF (ROOF),
        .ROUND(ROUND)
    ) u_post (
        .qg          (num_p0[WN-1:WIFA]),
        .sign        (sign_p0),
        .div0        (div0_p0),
        .dividend_neg(aneg_p0),
        .out         (post_out),
        .upflow      (post_up),
        .downflow    (post_down)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt_p0   <= '0;
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
            div0     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= BUSY;
                        cnt_p0 <= cnt_load;
                    end
                end
                BUSY: begin
                    if (last) begin
                        state    <= DONE;
                        out      <= post_out;
                        upflow   <= post_up;
                        downflow <= post_down;
                        div0     <= div0_p0;
                    end else begin
                        cnt_p0 <= cnt_p0 + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            state  <= BUSY;
                            cnt_p0 <= cnt_load;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
